// File: rtl/ucode_engine_if.sv
// Host-side bus of the microcoded engine.
//
// Handshake: the host may pulse start whenever busy is low. The engine
// samples start only in IDLE. busy is high for every cycle the engine executes
// microcode. done is a single-cycle pulse, with busy already low, that marks
// the end of a run. err and steps are valid while done is high and hold until
// the next accepted start. Program and operand writes (prog_we, ld_we) are
// honoured only while the engine is idle. rd_idx/rd_data is an asynchronous
// read port that is usable in every state.
//
// Signals
//   start, busy, done, err, steps   run control and status
//   prog_we, prog_addr, prog_data   microcode write port
//   ld_we, ld_idx, ld_data          register-file write port
//   rd_idx, rd_data                 register-file read port
interface ucode_engine_if #(
  parameter int P_WIDTH       = 32,
  parameter int P_NUM_REGS    = 4,
  parameter int P_LOG_MEMSIZE = 4,
  parameter int P_STEP_W      = 10
);
  localparam int R = $clog2(P_NUM_REGS);
  localparam int L = P_LOG_MEMSIZE;
  localparam int I = 3 + 2 * R + L;

  logic                start;
  logic                busy;
  logic                done;
  logic                err;
  logic [P_STEP_W-1:0] steps;
  logic                prog_we;
  logic [L-1:0]        prog_addr;
  logic [I-1:0]        prog_data;
  logic                ld_we;
  logic [R-1:0]        ld_idx;
  logic [P_WIDTH-1:0]  ld_data;
  logic [R-1:0]        rd_idx;
  logic [P_WIDTH-1:0]  rd_data;

  modport master (
    output start, prog_we, prog_addr, prog_data, ld_we, ld_idx, ld_data, rd_idx,
    input  busy, done, err, steps, rd_data
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, ld_we, ld_idx, ld_data, rd_idx,
    output busy, done, err, steps, rd_data
  );
endinterface

// File: rtl/ucode_engine.sv
// Microcoded datapath engine. It contains a register file of P_NUM_REGS
// operands, a writable microcode store of 2^P_LOG_MEMSIZE words and a
// branching sequencer. The engine executes one microinstruction per cycle
// until it reaches HALT or hits the step limit.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset; clears registers and microcode
//   bus        host bus (ucode_engine_if.slave): start/busy/done/err/steps,
//              microcode write port, register load port, register read port
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Microinstruction word: {opc[2:0], rd[R], rs[R], tgt[L]}
//   0 NOP  1 MOV  2 SUB  3 ADD  4 BEQ  5 BLT  6 JMP  7 HALT
module ucode_engine #(
  parameter int P_WIDTH       = 32,
  parameter int P_NUM_REGS    = 4,
  parameter int P_LOG_MEMSIZE = 4,
  parameter int P_STEP_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  ucode_engine_if.slave     bus,
  output logic [1:0]        state_dbg
);
  localparam int R     = $clog2(P_NUM_REGS);
  localparam int L     = P_LOG_MEMSIZE;
  localparam int I     = 3 + 2 * R + L;
  localparam int DEPTH = 1 << L;

  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BLT  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [P_WIDTH-1:0]  regs [P_NUM_REGS];
  logic [I-1:0]        mem  [DEPTH];
  logic [L-1:0]        pc, pc_nxt;
  logic [P_STEP_W-1:0] steps_q, steps_inc;
  logic                err_q;

  logic [I-1:0]        instr;
  logic [2:0]          opc;
  logic [R-1:0]        rd, rs;
  logic [L-1:0]        tgt;
  logic [P_WIDTH-1:0]  va, vb;
  logic                at_limit;

  // Decode the word at pc. Operand reads are combinational, so a register
  // written by one instruction is seen by the very next one.
  assign instr     = mem[pc];
  assign opc       = instr[I-1 -: 3];
  assign rd        = instr[L+R +: R];
  assign rs        = instr[L +: R];
  assign tgt       = instr[L-1:0];
  assign va        = regs[rd];
  assign vb        = regs[rs];
  assign steps_inc = steps_q + P_STEP_W'(1);
  // The instruction that brings the counter to all-ones is the last one
  // allowed. The counter therefore saturates there and never wraps.
  assign at_limit  = (steps_inc == {P_STEP_W{1'b1}});

  // Sequencer: pc+1 wraps naturally at the top of the store.
  always_comb begin
    pc_nxt = pc + L'(1);
    case (opc)
      OP_BEQ:  if (va == vb) pc_nxt = tgt;
      OP_BLT:  if (va < vb)  pc_nxt = tgt;
      OP_JMP:  pc_nxt = tgt;
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (opc == OP_HALT || at_limit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end

  assign bus.err     = err_q;
  assign bus.steps   = steps_q;
  assign bus.rd_data = regs[bus.rd_idx];
  assign state_dbg   = state;

  // Microcode store: host-writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_IDLE && bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Register file: the host writes it while idle, and microcode writes it while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P_NUM_REGS; i++) regs[i] <= '0;
    end else if (state == S_IDLE) begin
      if (bus.ld_we) regs[bus.ld_idx] <= bus.ld_data;
    end else if (state == S_RUN) begin
      case (opc)
        OP_MOV:  regs[rd] <= vb;
        OP_SUB:  regs[rd] <= va - vb;
        OP_ADD:  regs[rd] <= va + vb;
        default: ;
      endcase
    end
  end

  // Control registers: pc, step counter, timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pc      <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_RUN: begin
          steps_q <= steps_inc;
          pc      <= pc_nxt;
          if (opc != OP_HALT && at_limit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ucode_engine.sv
// Bench for ucode_engine. It uses two instances: a 32-bit engine with a
// 16-word store and 10-bit step counter, and an 8-bit engine with a 4-word
// store and 4-bit step counter for the timeout and pc-wrap cases.
module tb_ucode_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] m_state, s_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [31:0] exp_q[$];

  ucode_engine_if #(.P_WIDTH(32), .P_NUM_REGS(4), .P_LOG_MEMSIZE(4), .P_STEP_W(10)) m_if ();
  ucode_engine_if #(.P_WIDTH(8),  .P_NUM_REGS(4), .P_LOG_MEMSIZE(2), .P_STEP_W(4))  s_if ();

  ucode_engine #(.P_WIDTH(32), .P_NUM_REGS(4), .P_LOG_MEMSIZE(4), .P_STEP_W(10)) dut_m (
    .clk(clk), .rst(rst), .bus(m_if.slave), .state_dbg(m_state)
  );
  ucode_engine #(.P_WIDTH(8), .P_NUM_REGS(4), .P_LOG_MEMSIZE(2), .P_STEP_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(s_if.slave), .state_dbg(s_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [10:0] enc_m(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [3:0] tgt);
    return {op, rd, rs, tgt};
  endfunction

  function automatic logic [8:0] enc_s(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] tgt);
    return {op, rd, rs, tgt};
  endfunction

  // ---------------- driver tasks: 32-bit engine ----------------
  task automatic m_load(input logic [1:0] idx, input logic [31:0] val);
    @(negedge clk);
    m_if.ld_we = 1'b1; m_if.ld_idx = idx; m_if.ld_data = val;
    @(negedge clk);
    m_if.ld_we = 1'b0;
  endtask

  task automatic m_prog(input logic [3:0] addr, input logic [10:0] word);
    @(negedge clk);
    m_if.prog_we = 1'b1; m_if.prog_addr = addr; m_if.prog_data = word;
    @(negedge clk);
    m_if.prog_we = 1'b0;
  endtask

  task automatic m_read(input logic [1:0] idx, output logic [31:0] val);
    m_if.rd_idx = idx;
    #1;
    val = m_if.rd_data;
  endtask

  // Pulses start and counts edges from the start edge (inclusive) until done is seen.
  // With poke set, the task drives start, a microcode write and a register
  // load in the middle of the run. The engine must ignore all of them.
  task automatic run_main(input string tag, input int budget, input bit poke, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk); m_if.start = 1'b1;
    @(negedge clk); m_if.start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, m_if.busy, 1);
    check({tag, "_err_clr"}, m_if.err, 0);
    for (int i = 0; i < budget && !seen; i++) begin
      if (m_if.done) begin
        seen = 1'b1;
      end else begin
        if (poke && lat >= 2 && lat < 12) begin
          m_if.start = 1'b1;
          m_if.prog_we = 1'b1; m_if.prog_addr = 4'd6; m_if.prog_data = enc_m(3'd0, 2'd0, 2'd0, 4'd0);
          m_if.ld_we = 1'b1; m_if.ld_idx = 2'd0; m_if.ld_data = 32'd99;
        end else begin
          m_if.start = 1'b0; m_if.prog_we = 1'b0; m_if.ld_we = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    m_if.start = 1'b0; m_if.prog_we = 1'b0; m_if.ld_we = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_at_done"}, m_if.busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, m_if.done, 0);
  endtask

  // ---------------- driver tasks: 8-bit engine ----------------
  task automatic s_load(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk);
    s_if.ld_we = 1'b1; s_if.ld_idx = idx; s_if.ld_data = val;
    @(negedge clk);
    s_if.ld_we = 1'b0;
  endtask

  task automatic s_prog(input logic [1:0] addr, input logic [8:0] word);
    @(negedge clk);
    s_if.prog_we = 1'b1; s_if.prog_addr = addr; s_if.prog_data = word;
    @(negedge clk);
    s_if.prog_we = 1'b0;
  endtask

  task automatic run_small(input string tag, input int budget, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk); s_if.start = 1'b1;
    @(negedge clk); s_if.start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, s_if.busy, 1);
    check({tag, "_err_clr"}, s_if.err, 0);
    for (int i = 0; i < budget && !seen; i++) begin
      if (s_if.done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, s_if.done, 0);
  endtask

  // ---------------- single-instruction vector table ----------------
  // Program: mem[0]=instr (tgt 8), mem[1]=HALT, mem[8]=NOP, mem[9]=HALT.
  // A taken branch or jump runs 3 steps. Fall-through runs 2 steps.
  typedef struct {
    string       name;
    logic [2:0]  opc;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [31:0] a;       // loaded into r0
    logic [31:0] b;       // loaded into r1
    logic [31:0] exp_val; // expected r[rd] after the run
    int          exp_steps;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int          lat;
    logic [31:0] val;

    rst = 1'b1;
    m_if.start = 0; m_if.prog_we = 0; m_if.prog_addr = 0; m_if.prog_data = 0;
    m_if.ld_we = 0; m_if.ld_idx = 0; m_if.ld_data = 0; m_if.rd_idx = 0;
    s_if.start = 0; s_if.prog_we = 0; s_if.prog_addr = 0; s_if.prog_data = 0;
    s_if.ld_we = 0; s_if.ld_idx = 0; s_if.ld_data = 0; s_if.rd_idx = 0;

    vecs[0]  = '{"mov",      3'd1, 2'd0, 2'd1, 32'd5,          32'd77, 32'd77,          2};
    vecs[1]  = '{"sub",      3'd2, 2'd0, 2'd1, 32'd100,        32'd30, 32'd70,          2};
    vecs[2]  = '{"sub_wrap", 3'd2, 2'd0, 2'd1, 32'd3,          32'd5,  32'hFFFF_FFFE,   2};
    vecs[3]  = '{"add_wrap", 3'd3, 2'd0, 2'd1, 32'hFFFF_FFFF,  32'd2,  32'd1,           2};
    vecs[4]  = '{"add_self", 3'd3, 2'd0, 2'd0, 32'h4000_0000,  32'd7,  32'h8000_0000,   2};
    vecs[5]  = '{"sub_self", 3'd2, 2'd1, 2'd1, 32'd11,         32'd22, 32'd0,           2};
    vecs[6]  = '{"beq_eq",   3'd4, 2'd0, 2'd1, 32'd9,          32'd9,  32'd9,           3};
    vecs[7]  = '{"beq_ne",   3'd4, 2'd0, 2'd1, 32'd9,          32'd10, 32'd9,           2};
    vecs[8]  = '{"blt_lt",   3'd5, 2'd0, 2'd1, 32'd3,          32'd4,  32'd3,           3};
    vecs[9]  = '{"blt_gt",   3'd5, 2'd0, 2'd1, 32'd4,          32'd3,  32'd4,           2};
    vecs[10] = '{"blt_eq",   3'd5, 2'd0, 2'd1, 32'd4,          32'd4,  32'd4,           2};
    vecs[11] = '{"blt_self", 3'd5, 2'd0, 2'd0, 32'd1,          32'd5,  32'd1,           2};
    vecs[12] = '{"beq_self", 3'd4, 2'd1, 2'd1, 32'd1,          32'd5,  32'd5,           3};
    vecs[13] = '{"nop",      3'd0, 2'd0, 2'd1, 32'd6,          32'd7,  32'd6,           2};
    vecs[14] = '{"jmp",      3'd6, 2'd0, 2'd1, 32'd6,          32'd7,  32'd6,           3};
    vecs[15] = '{"halt",     3'd7, 2'd0, 2'd1, 32'd6,          32'd7,  32'd6,           1};
    for (int i = 0; i < 16; i++) exp_q.push_back(vecs[i].exp_val);

    // ---- reset state ----
    #12;
    check("rst_busy",   m_if.busy, 0);
    check("rst_done",   m_if.done, 0);
    check("rst_err",    m_if.err, 0);
    check("rst_steps",  m_if.steps, 0);
    check("rst_state",  m_state, 0);
    check("rst_rd0",    m_if.rd_data, 0);
    check("rst_s_busy", s_if.busy, 0);
    check("rst_s_state", s_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven single instructions ----
    m_prog(4'd1, enc_m(3'd7, 2'd0, 2'd0, 4'd0));
    m_prog(4'd8, enc_m(3'd0, 2'd0, 2'd0, 4'd0));
    m_prog(4'd9, enc_m(3'd7, 2'd0, 2'd0, 4'd0));
    for (int i = 0; i < 16; i++) begin
      logic [31:0] expv;
      expv = exp_q.pop_front();
      m_load(2'd0, vecs[i].a);
      m_load(2'd1, vecs[i].b);
      m_prog(4'd0, enc_m(vecs[i].opc, vecs[i].rd, vecs[i].rs, 4'd8));
      run_main(vecs[i].name, 40, 1'b0, lat);
      m_read(vecs[i].rd, val);
      check({vecs[i].name, "_result"}, val, expv);
      check({vecs[i].name, "_steps"}, m_if.steps, vecs[i].exp_steps);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_steps + 1);
      check({vecs[i].name, "_err"}, m_if.err, 0);
    end

    // ---- wraparound arithmetic ----
    m_load(2'd2, 32'd0);
    m_load(2'd3, 32'd1);
    m_prog(4'd0, enc_m(3'd2, 2'd2, 2'd3, 4'd0));
    m_prog(4'd1, enc_m(3'd3, 2'd3, 2'd2, 4'd0));
    m_prog(4'd2, enc_m(3'd7, 2'd0, 2'd0, 4'd0));
    run_main("wrap", 40, 1'b0, lat);
    m_read(2'd2, val); check("wrap_r2", val, 32'hFFFF_FFFF);
    m_read(2'd3, val); check("wrap_r3", val, 32'd0);
    check("wrap_steps", m_if.steps, 3);

    // ---- GCD(48, 18) ----
    m_prog(4'd0, enc_m(3'd4, 2'd0, 2'd1, 4'd6));
    m_prog(4'd1, enc_m(3'd5, 2'd0, 2'd1, 4'd4));
    m_prog(4'd2, enc_m(3'd2, 2'd0, 2'd1, 4'd0));
    m_prog(4'd3, enc_m(3'd6, 2'd0, 2'd0, 4'd0));
    m_prog(4'd4, enc_m(3'd2, 2'd1, 2'd0, 4'd0));
    m_prog(4'd5, enc_m(3'd6, 2'd0, 2'd0, 4'd0));
    m_prog(4'd6, enc_m(3'd7, 2'd0, 2'd0, 4'd0));
    m_load(2'd0, 32'd48);
    m_load(2'd1, 32'd18);
    run_main("gcd", 60, 1'b0, lat);
    check("gcd_latency", lat, 19);
    check("gcd_steps", m_if.steps, 18);
    check("gcd_err", m_if.err, 0);
    m_read(2'd0, val); check("gcd_r0", val, 6);
    m_read(2'd1, val); check("gcd_r1", val, 6);

    // ---- GCD with host writes and start attempted mid-run ----
    m_load(2'd0, 32'd48);
    m_load(2'd1, 32'd18);
    run_main("lock", 60, 1'b1, lat);
    check("lock_latency", lat, 19);
    check("lock_steps", m_if.steps, 18);
    m_read(2'd0, val); check("lock_r0", val, 6);
    m_read(2'd1, val); check("lock_r1", val, 6);

    // ---- reset in the middle of a GCD run ----
    m_load(2'd0, 32'd48);
    m_load(2'd1, 32'd18);
    @(negedge clk); m_if.start = 1'b1;
    @(negedge clk); m_if.start = 1'b0;
    for (int i = 0; i < 50 && m_if.steps != 10'd5; i++) @(negedge clk);
    check("mid_steps5", m_if.steps, 5);
    rst = 1'b1;
    #1;
    check("mid_busy",  m_if.busy, 0);
    check("mid_done",  m_if.done, 0);
    check("mid_state", m_state, 0);
    check("mid_steps", m_if.steps, 0);
    for (int i = 0; i < 4; i++) begin
      m_read(2'(i), val);
      check("mid_reg_clear", val, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    // The store is now all NOP, so pc wraps around until the step limit.
    run_main("mid_restart", 1100, 1'b0, lat);
    check("mid_restart_steps", m_if.steps, 1023);
    check("mid_restart_err", m_if.err, 1);
    check("mid_restart_latency", lat, 1024);

    // ---- 8-bit engine: NOP-only timeout, JMP-0 timeout, err clear, pc wrap ----
    run_small("s_nop", 40, lat);
    check("s_nop_steps", s_if.steps, 15);
    check("s_nop_err", s_if.err, 1);
    check("s_nop_latency", lat, 16);

    s_prog(2'd0, enc_s(3'd6, 2'd0, 2'd0, 2'd0));
    run_small("s_jmp", 40, lat);
    check("s_jmp_steps", s_if.steps, 15);
    check("s_jmp_err", s_if.err, 1);

    s_prog(2'd0, enc_s(3'd7, 2'd0, 2'd0, 2'd0));
    run_small("s_halt", 40, lat);
    check("s_halt_steps", s_if.steps, 1);
    check("s_halt_err", s_if.err, 0);

    s_load(2'd0, 8'd0);
    s_load(2'd1, 8'd1);
    s_prog(2'd0, enc_s(3'd5, 2'd0, 2'd1, 2'd2));
    s_prog(2'd1, enc_s(3'd7, 2'd0, 2'd0, 2'd0));
    s_prog(2'd2, enc_s(3'd0, 2'd0, 2'd0, 2'd0));
    s_prog(2'd3, enc_s(3'd3, 2'd0, 2'd1, 2'd0));
    run_small("s_pcwrap", 40, lat);
    check("s_pcwrap_steps", s_if.steps, 5);
    check("s_pcwrap_err", s_if.err, 0);
    s_if.rd_idx = 2'd0;
    #1;
    check("s_pcwrap_r0", s_if.rd_data, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
